// File: rtl/ship_placer.sv
// Ship-placement controller for the player's board: clears the board RAM, steers the
// placement cursor, overlap-checks each ship against the RAM and writes SHIP cells.
module ship_placer #(
    parameter int GRID   = 10,
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_rotate,
    input  logic              btn_place,
    input  logic [1:0]        ram_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [1:0]        ram_wdata,
    output logic              ram_we,
    output logic [7:0]        cursor,
    output logic              ghost_ship,
    output logic [2:0]        ship_idx,
    output logic              place_err,
    output logic              busy,
    output logic              done
);
    localparam int         CELLS = GRID * GRID;
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] SHIP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_AIM, S_CHECK, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t      state, state_d;
    logic [3:0]  cur_x, cur_y;
    logic        vert;
    logic [2:0]  k;
    logic        iss_vld, cmp_vld, cmp_last;
    logic [2:0]  len;
    logic [3:0]  lim, x_max, y_max;
    logic        k_last, clr_last, chk_hit, chk_done;
    logic        busy_d, done_d, ghost_d;

    function automatic logic [2:0] ship_len(input logic [2:0] idx);
        case (idx)
            3'd0:    ship_len = 3'd5;
            3'd1:    ship_len = 3'd4;
            3'd2:    ship_len = 3'd3;
            3'd3:    ship_len = 3'd3;
            default: ship_len = 3'd2;
        endcase
    endfunction

    function automatic logic [RAM_AW-1:0] cell_addr(input logic [3:0] cx, input logic [3:0] cy,
                                                    input logic cv, input logic [2:0] ck);
        logic [RAM_AW-1:0] ax, ay;
        ax = RAM_AW'(cx) + (cv ? RAM_AW'(0) : RAM_AW'(ck));
        ay = RAM_AW'(cy) + (cv ? RAM_AW'(ck) : RAM_AW'(0));
        cell_addr = ay * RAM_AW'(GRID) + ax;
    endfunction

    assign cursor   = {cur_x, cur_y};
    assign len      = ship_len(ship_idx);
    // Largest anchor along the ship's own axis that still keeps the whole hull on the board.
    assign lim      = 4'(GRID) - {1'b0, len};
    assign x_max    = vert ? 4'(GRID - 1) : lim;
    assign y_max    = vert ? lim : 4'(GRID - 1);
    assign k_last   = (k == len - 3'd1);
    assign clr_last = (ram_addr == RAM_AW'(CELLS - 1));
    // cmp_vld marks that ram_rdata carries the cell read on the previous cycle.
    assign chk_hit  = cmp_vld && (ram_rdata == SHIP);
    assign chk_done = cmp_vld && cmp_last && (ram_rdata != SHIP);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (start) begin
            state_d = S_CLEAR;
        end else begin
            case (state)
                S_IDLE:  state_d = S_IDLE;
                S_CLEAR: if (clr_last) state_d = S_AIM;
                S_AIM:   if (btn_place) state_d = S_CHECK;
                S_CHECK: begin
                    if (chk_hit)       state_d = S_AIM;
                    else if (chk_done) state_d = S_WRITE;
                end
                S_WRITE: if (k_last) state_d = S_NEXT;
                S_NEXT:  state_d = (ship_idx == 3'd4) ? S_DONE : S_AIM;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_d  = (state_d == S_CLEAR) || (state_d == S_CHECK) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
        ghost_d = (state_d == S_AIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_x      <= '0;
            cur_y      <= '0;
            vert       <= 1'b0;
            k          <= '0;
            iss_vld    <= 1'b0;
            cmp_vld    <= 1'b0;
            cmp_last   <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= EMPTY;
            ram_we     <= 1'b0;
            ship_idx   <= '0;
            place_err  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ghost_ship <= 1'b0;
        end else begin
            place_err  <= 1'b0;
            busy       <= busy_d;
            done       <= done_d;
            ghost_ship <= ghost_d;
            if (start) begin
                ram_addr  <= '0;
                ram_wdata <= EMPTY;
                ram_we    <= 1'b1;
                ship_idx  <= '0;
                cur_x     <= '0;
                cur_y     <= '0;
                vert      <= 1'b0;
                iss_vld   <= 1'b0;
                cmp_vld   <= 1'b0;
                cmp_last  <= 1'b0;
            end else begin
                case (state)
                    S_CLEAR: begin
                        if (clr_last) begin
                            ram_we   <= 1'b0;
                            ship_idx <= '0;
                            cur_x    <= '0;
                            cur_y    <= '0;
                            vert     <= 1'b0;
                        end else begin
                            ram_addr <= ram_addr + RAM_AW'(1);
                        end
                    end
                    S_AIM: begin
                        if (btn_place) begin
                            k        <= '0;
                            ram_addr <= cell_addr(cur_x, cur_y, vert, 3'd0);
                            iss_vld  <= 1'b1;
                            cmp_vld  <= 1'b0;
                            cmp_last <= 1'b0;
                        end else if (btn_rotate) begin
                            vert <= ~vert;
                            if (!vert && cur_y > lim) cur_y <= lim;
                            if (vert && cur_x > lim)  cur_x <= lim;
                        end else if (btn_up) begin
                            if (cur_y != 4'd0) cur_y <= cur_y - 4'd1;
                        end else if (btn_down) begin
                            if (cur_y < y_max) cur_y <= cur_y + 4'd1;
                        end else if (btn_left) begin
                            if (cur_x != 4'd0) cur_x <= cur_x - 4'd1;
                        end else if (btn_right) begin
                            if (cur_x < x_max) cur_x <= cur_x + 4'd1;
                        end
                    end
                    S_CHECK: begin
                        cmp_vld  <= iss_vld;
                        cmp_last <= iss_vld && k_last;
                        if (chk_hit) begin
                            place_err <= 1'b1;
                            iss_vld   <= 1'b0;
                            cmp_vld   <= 1'b0;
                        end else if (chk_done) begin
                            k         <= '0;
                            ram_addr  <= cell_addr(cur_x, cur_y, vert, 3'd0);
                            ram_wdata <= SHIP;
                            ram_we    <= 1'b1;
                            iss_vld   <= 1'b0;
                            cmp_vld   <= 1'b0;
                        end else if (iss_vld && !k_last) begin
                            k        <= k + 3'd1;
                            ram_addr <= cell_addr(cur_x, cur_y, vert, k + 3'd1);
                        end else begin
                            iss_vld <= 1'b0;
                        end
                    end
                    S_WRITE: begin
                        if (k_last) begin
                            ram_we <= 1'b0;
                        end else begin
                            k        <= k + 3'd1;
                            ram_addr <= cell_addr(cur_x, cur_y, vert, k + 3'd1);
                        end
                    end
                    S_NEXT: begin
                        ship_idx <= ship_idx + 3'd1;
                        cur_x    <= '0;
                        cur_y    <= '0;
                        vert     <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ship_placer.sv
// Directed bench for ship_placer: behavioural board RAM, write/err monitor, and
// hand-computed expectations for clear, cursor moves, placement, conflict and abort.
module tb_ship_placer;
    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, ROT = 4, PLACE = 5;

    logic       clk = 1'b0;
    logic       rst, start, fill;
    logic       btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_place;
    logic [1:0] ram_rdata;
    logic [9:0] ram_addr;
    logic [1:0] ram_wdata;
    logic       ram_we;
    logic [7:0] cursor;
    logic       ghost_ship;
    logic [2:0] ship_idx;
    logic       place_err, busy, done;

    int n_chk = 0, n_err = 0, cyc = 0;
    int ship_wr = 0, pe_cnt = 0, pe_cyc = 0;
    int w_addr[$], w_data[$], w_cyc[$], exp_q[$];
    logic [1:0] mem [0:1023];

    always #5 clk = ~clk;

    ship_placer #(.GRID(10), .RAM_AW(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_rotate(btn_rotate), .btn_place(btn_place),
        .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .cursor(cursor), .ghost_ship(ghost_ship), .ship_idx(ship_idx),
        .place_err(place_err), .busy(busy), .done(done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Board RAM with one-cycle read latency; power-up contents are all SHIP so a missed clear shows.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 2'd3;
            ram_rdata <= 2'd0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (ram_we) begin
            w_addr.push_back(int'(ram_addr));
            w_data.push_back(int'(ram_wdata));
            w_cyc.push_back(cyc);
            if (ram_wdata == 2'd3) ship_wr++;
        end
        if (place_err) begin
            pe_cnt++;
            pe_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int b, input int n);
        repeat (n) begin
            btn_up     = (b == UP);
            btn_down   = (b == DOWN);
            btn_left   = (b == LEFT);
            btn_right  = (b == RIGHT);
            btn_rotate = (b == ROT);
            btn_place  = (b == PLACE);
            tick(1);
            {btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_place} = '0;
        end
    endtask

    task automatic clr_log();
        w_addr.delete();
        w_data.delete();
        w_cyc.delete();
        pe_cnt = 0;
    endtask

    task automatic wait_aim(input string tag, output int at);
        int n = 0;
        while (!ghost_ship && !done && n < 60) begin
            tick(1);
            n++;
        end
        chk({tag, "_return"}, int'(ghost_ship || done), 1);
        at = cyc;
    endtask

    // Compares the write log with exp_q (all SHIP, on consecutive cycles).
    task automatic chk_writes(input string tag);
        int bad = 0;
        chk({tag, "_nwr"}, w_addr.size(), exp_q.size());
        for (int i = 0; i < w_addr.size() && i < exp_q.size(); i++)
            if (w_addr[i] != exp_q[i] || w_data[i] != 3 || w_cyc[i] != w_cyc[0] + i) bad++;
        chk({tag, "_wr_bad"}, bad, 0);
    endtask

    function automatic int board_nz();
        int nz = 0;
        for (int i = 0; i < 100; i++) if (mem[i] != 2'd0) nz++;
        return nz;
    endfunction

    task automatic place_ok(input string tag, output int t0, output int at);
        clr_log();
        t0 = cyc;
        press(PLACE, 1);
        wait_aim(tag, at);
        tick(1);
        chk_writes(tag);
    endtask

    initial begin
        int t0, at, bc, bad;
        rst = 1'b1; fill = 1'b1; start = 1'b0;
        {btn_up, btn_down, btn_left, btn_right, btn_rotate, btn_place} = '0;
        tick(3);
        chk("rst_cursor", cursor, 0);
        chk("rst_ship_idx", ship_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ghost", ghost_ship, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_err", place_err, 0);
        fill = 1'b0; rst = 1'b0;
        tick(2);
        chk("idle_busy", busy, 0);

        // Clear: 100 writes of EMPTY in address order, starting the cycle after start.
        clr_log();
        t0 = cyc;
        start = 1'b1; tick(1); start = 1'b0;
        bc = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) bc++;
            tick(1);
        end
        chk("clr_busy_cycles", bc, 100);
        chk("clr_nwr", w_addr.size(), 100);
        bad = 0;
        for (int i = 0; i < w_addr.size(); i++)
            if (w_addr[i] != i || w_data[i] != 0 || w_cyc[i] != t0 + 1 + i) bad++;
        chk("clr_order", bad, 0);
        chk("clr_busy_off", busy, 0);
        chk("clr_ghost", ghost_ship, 1);
        chk("clr_cursor", cursor, 0);
        chk("clr_ship_idx", ship_idx, 0);
        chk("clr_board", board_nz(), 0);
        ship_wr = 0;

        // Cursor limits for the length-5 ship.
        press(RIGHT, 7);  chk("right_sat", cursor, 8'h50);
        press(DOWN, 12);  chk("down_sat", cursor, 8'h59);
        press(ROT, 1);    chk("rot_clamp", cursor, 8'h55);
        press(ROT, 1);    chk("rot_back", cursor, 8'h55);
        press(LEFT, 6);   chk("left_sat", cursor, 8'h05);
        press(UP, 6);     chk("up_sat", cursor, 8'h00);
        btn_down = 1'b1; btn_right = 1'b1; tick(1);
        btn_down = 1'b0; btn_right = 1'b0;
        chk("prio_down_right", cursor, 8'h01);
        press(UP, 1);     chk("prio_restore", cursor, 8'h00);

        // Ship 0 at (0,0) horizontal: reads t+1..t+5, writes t+7..t+11, AIM at t+13.
        exp_q = '{0, 1, 2, 3, 4};
        place_ok("s0", t0, at);
        chk("s0_aim_cyc", at, t0 + 13);
        chk("s0_wr_cyc", (w_cyc.size() > 0) ? w_cyc[0] : -1, t0 + 7);
        chk("s0_ship_idx", ship_idx, 1);
        chk("s0_cursor", cursor, 8'h00);

        // Ship 1 vertical at (2,0) overlaps ship 0 on its first cell.
        press(ROT, 1);
        press(RIGHT, 2);
        chk("s1_aim_cursor", cursor, 8'h20);
        clr_log();
        t0 = cyc;
        press(PLACE, 1);
        wait_aim("s1_hit", at);
        chk("s1_hit_aim_cyc", at, t0 + 3);
        tick(2);
        chk("s1_hit_err_cnt", pe_cnt, 1);
        chk("s1_hit_err_win", int'(pe_cyc >= t0 + 2 && pe_cyc <= t0 + 3), 1);
        chk("s1_hit_nwr", w_addr.size(), 0);
        chk("s1_hit_cursor", cursor, 8'h20);
        chk("s1_hit_ship_idx", ship_idx, 1);

        // Remaining fleet, no overlap.
        press(RIGHT, 7);
        chk("s1_cursor", cursor, 8'h90);
        exp_q = '{9, 19, 29, 39};
        place_ok("s1", t0, at);
        chk("s1_aim_cyc", at, t0 + 11);
        press(DOWN, 2);
        exp_q = '{20, 21, 22};
        place_ok("s2", t0, at);
        press(DOWN, 4);
        exp_q = '{40, 41, 42};
        place_ok("s3", t0, at);
        press(ROT, 1);
        press(RIGHT, 5);
        press(DOWN, 9);
        chk("s4_vsat", cursor, 8'h58);
        press(UP, 3);
        exp_q = '{55, 65};
        place_ok("s4", t0, at);
        chk("fleet_ship_wr", ship_wr, 17);
        chk("fleet_idx", ship_idx, 5);
        chk("fleet_done", done, 1);
        chk("fleet_ghost", ghost_ship, 0);
        chk("fleet_busy", busy, 0);

        // Buttons are ignored once the fleet is complete.
        clr_log();
        for (int b = 0; b < 6; b++) press(b, 1);
        tick(5);
        chk("done_nwr", w_addr.size(), 0);
        chk("done_cursor", cursor, 8'h00);
        chk("done_hold", done, 1);
        chk("done_busy", busy, 0);
        chk("done_err", pe_cnt, 0);

        // Second game: start during ship 2's WRITE aborts into a fresh clear.
        start = 1'b1; tick(1); start = 1'b0;
        tick(100);
        chk("g2_ghost", ghost_ship, 1);
        chk("g2_board", board_nz(), 0);
        exp_q = '{0, 1, 2, 3, 4};
        place_ok("g2s0", t0, at);
        press(DOWN, 1);
        exp_q = '{10, 11, 12, 13};
        place_ok("g2s1", t0, at);
        press(DOWN, 2);
        clr_log();
        t0 = cyc;
        press(PLACE, 1);
        tick(5);
        start = 1'b1; tick(1); start = 1'b0;
        chk("abort_we", ram_we, 1);
        chk("abort_addr", ram_addr, 0);
        chk("abort_wdata", ram_wdata, 0);
        chk("abort_busy", busy, 1);
        tick(100);
        chk("abort_ghost", ghost_ship, 1);
        chk("abort_ship_idx", ship_idx, 0);
        chk("abort_cursor", cursor, 8'h00);
        chk("abort_board", board_nz(), 0);
        bad = 0;
        if (w_addr.size() < 3) bad = 99;
        else begin
            if (w_addr[0] != 20 || w_data[0] != 3 || w_cyc[0] != t0 + 5) bad++;
            if (w_addr[1] != 21 || w_data[1] != 3 || w_cyc[1] != t0 + 6) bad++;
            if (w_addr[2] != 0  || w_data[2] != 0 || w_cyc[2] != t0 + 7) bad++;
        end
        chk("abort_seq", bad, 0);

        // Reset wins over a coincident start.
        rst = 1'b1; start = 1'b1; tick(1); start = 1'b0;
        chk("rst_start_busy", busy, 0);
        chk("rst_start_we", ram_we, 0);
        chk("rst_start_ghost", ghost_ship, 0);
        rst = 1'b0; tick(2);
        chk("rst_start_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
